// File: rtl/serial_pack_pkg.sv
// Shared constants and state encodings for the serial pack scheduler.
package serial_pack_pkg;

    localparam logic [7:0] ACK_OK     = 8'hA5;
    localparam logic [7:0] ACK_FULL   = 8'hEE;
    localparam logic [7:0] ACK_FLUSH  = 8'h5A;
    localparam logic [7:0] CTRL_FLUSH = 8'hFF;

    typedef enum logic {
        A_IDLE    = 1'b0,
        A_COLLECT = 1'b1
    } asm_state_e;

    typedef enum logic [1:0] {
        D_IDLE  = 2'd0,
        D_START = 2'd1,
        D_WAIT  = 2'd2
    } disp_state_e;

endpackage

// File: rtl/pack_fifo.sv
// Small circular queue of complete packs; flush beats push, push+pop allowed when full.
module pack_fifo #(
    parameter int unsigned WIDTH = 72,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_c_o,
    output logic             full_c_o,
    output logic             empty_c_o,
    output logic [PW:0]      level_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty_c_o = (cnt_q == '0);
    assign full_c_o  = (cnt_q == (PW+1)'(DEPTH));
    assign head_c_o  = mem_q[rd_ptr_q];
    assign level_o   = cnt_q;

    assign do_pop  = pop_i && !empty_c_o;
    assign do_push = push_i && !flush_i && (!full_c_o || do_pop);

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/serial_pack_scheduler.sv
// Frames UART bytes into packs, queues them, dispatches to the serial engine and acks each pack.
module serial_pack_scheduler
    import serial_pack_pkg::*;
#(
    parameter int unsigned DATA_BIT    = 32,
    parameter int unsigned PACK_NUM    = (DATA_BIT/8)*2+1,
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned TIMEOUT_CYC = 20000,
    localparam int unsigned LVL_W      = $clog2(DEPTH)+1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          i_data,
    input  logic                i_rx_done_tick,
    input  logic                i_busy,
    input  logic                i_done_tick,
    output logic                o_start,
    output logic [DATA_BIT-1:0] o_pattern,
    output logic [DATA_BIT-1:0] o_freq,
    output logic [7:0]          o_ctrl,
    input  logic                i_tx_ready,
    output logic                o_tx_start,
    output logic [7:0]          o_tx_data,
    output logic                o_frame_err,
    output logic [LVL_W-1:0]    o_q_level
);

    localparam int unsigned PACK_W = DATA_BIT*2+8;
    localparam int unsigned CNT_W  = $clog2(PACK_NUM);
    localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYC);

    // Assembler state
    asm_state_e          asm_state_q, asm_state_d;
    logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
    logic [PACK_W-9:0]   shreg_q, shreg_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                frame_err_q, frame_err_d;
    logic                pack_done_c;
    logic [PACK_W-1:0]   pack_c;

    // Dispatch state
    disp_state_e         disp_q, disp_d;
    logic                start_q, start_d;
    logic [PACK_W-1:0]   out_q, out_d;
    logic                pop_c;

    // Ack state
    logic                ack_pend_q, ack_pend_d;
    logic [7:0]          ack_code_q, ack_code_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic [7:0]          ack_sel_c;
    logic                is_flush_c;

    // Queue interface
    logic [PACK_W-1:0]   head_c;
    logic                full_c;
    logic                empty_c;
    logic [LVL_W-1:0]    level;

    assign pack_c     = {shreg_q, i_data};
    assign is_flush_c = pack_done_c && (i_data == CTRL_FLUSH);

    pack_fifo #(
        .WIDTH (PACK_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (pack_done_c && !is_flush_c),
        .pop_i     (pop_c),
        .flush_i   (is_flush_c),
        .din_i     (pack_c),
        .head_c_o  (head_c),
        .full_c_o  (full_c),
        .empty_c_o (empty_c),
        .level_o   (level)
    );

    // Byte framing with inter-byte timeout; a byte in the expiry cycle is accepted.
    always_comb begin
        asm_state_d = asm_state_q;
        byte_cnt_d  = byte_cnt_q;
        shreg_d     = shreg_q;
        tmo_d       = tmo_q;
        frame_err_d = 1'b0;
        pack_done_c = 1'b0;
        case (asm_state_q)
            A_IDLE: begin
                tmo_d = '0;
                if (i_rx_done_tick) begin
                    shreg_d     = {shreg_q[PACK_W-17:0], i_data};
                    byte_cnt_d  = CNT_W'(1);
                    asm_state_d = A_COLLECT;
                end
            end
            A_COLLECT: begin
                if (i_rx_done_tick) begin
                    tmo_d   = '0;
                    shreg_d = {shreg_q[PACK_W-17:0], i_data};
                    if (byte_cnt_q == CNT_W'(PACK_NUM-1)) begin
                        pack_done_c = 1'b1;
                        byte_cnt_d  = '0;
                        asm_state_d = A_IDLE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else if (tmo_q == TMO_W'(TIMEOUT_CYC-1)) begin
                    frame_err_d = 1'b1;
                    tmo_d       = '0;
                    byte_cnt_d  = '0;
                    asm_state_d = A_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: asm_state_d = A_IDLE;
        endcase
    end

    // Queue-to-engine launch sequencing; launch waits for the engine to be idle.
    always_comb begin
        disp_d  = disp_q;
        start_d = 1'b0;
        out_d   = out_q;
        pop_c   = 1'b0;
        case (disp_q)
            D_IDLE: begin
                if (!empty_c && !i_busy) begin
                    pop_c  = 1'b1;
                    out_d  = head_c;
                    disp_d = D_START;
                end
            end
            D_START: begin
                if (!i_busy) begin
                    start_d = 1'b1;
                    disp_d  = D_WAIT;
                end
            end
            D_WAIT: begin
                if (i_done_tick) disp_d = D_IDLE;
            end
            default: disp_d = D_IDLE;
        endcase
    end

    // Ack code selection and single-slot pending ack (newest code wins).
    always_comb begin
        ack_pend_d = ack_pend_q;
        ack_code_d = ack_code_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        if (is_flush_c)            ack_sel_c = ACK_FLUSH;
        else if (!full_c || pop_c) ack_sel_c = ACK_OK;
        else                       ack_sel_c = ACK_FULL;
        if (ack_pend_q && i_tx_ready) begin
            tx_start_d = 1'b1;
            tx_data_d  = ack_code_q;
            ack_pend_d = 1'b0;
        end
        if (pack_done_c) begin
            ack_pend_d = 1'b1;
            ack_code_d = ack_sel_c;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_q <= A_IDLE;
            byte_cnt_q  <= '0;
            shreg_q     <= '0;
            tmo_q       <= '0;
            frame_err_q <= 1'b0;
            disp_q      <= D_IDLE;
            start_q     <= 1'b0;
            out_q       <= '0;
            ack_pend_q  <= 1'b0;
            ack_code_q  <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            asm_state_q <= asm_state_d;
            byte_cnt_q  <= byte_cnt_d;
            shreg_q     <= shreg_d;
            tmo_q       <= tmo_d;
            frame_err_q <= frame_err_d;
            disp_q      <= disp_d;
            start_q     <= start_d;
            out_q       <= out_d;
            ack_pend_q  <= ack_pend_d;
            ack_code_q  <= ack_code_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign o_start     = start_q;
    assign o_pattern   = out_q[PACK_W-1 -: DATA_BIT];
    assign o_freq      = out_q[DATA_BIT+7 -: DATA_BIT];
    assign o_ctrl      = out_q[7:0];
    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_frame_err = frame_err_q;
    assign o_q_level   = level;

endmodule

// File: tb/tb_serial_pack_scheduler.sv
// Randomized and directed checks of serial_pack_scheduler against a queue-level reference model.
module tb_serial_pack_scheduler;

    localparam int unsigned DATA_BIT    = 32;
    localparam int unsigned PACK_NUM    = 9;
    localparam int unsigned DEPTH       = 2;
    localparam int unsigned TIMEOUT_CYC = 40;
    localparam int unsigned PACK_W      = DATA_BIT*2+8;
    localparam int unsigned LVL_W       = $clog2(DEPTH)+1;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          i_data = 8'h00;
    logic                i_rx_done_tick = 1'b0;
    wire                 i_busy;
    logic                i_done_tick = 1'b0;
    logic                o_start;
    logic [DATA_BIT-1:0] o_pattern;
    logic [DATA_BIT-1:0] o_freq;
    logic [7:0]          o_ctrl;
    logic                i_tx_ready = 1'b1;
    logic                o_tx_start;
    logic [7:0]          o_tx_data;
    logic                o_frame_err;
    logic [LVL_W-1:0]    o_q_level;

    serial_pack_scheduler #(
        .DATA_BIT(DATA_BIT), .PACK_NUM(PACK_NUM), .DEPTH(DEPTH), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_rx_done_tick(i_rx_done_tick),
        .i_busy(i_busy), .i_done_tick(i_done_tick), .o_start(o_start),
        .o_pattern(o_pattern), .o_freq(o_freq), .o_ctrl(o_ctrl),
        .i_tx_ready(i_tx_ready), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
        .o_frame_err(o_frame_err), .o_q_level(o_q_level)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Engine stand-in: busy for eng_len cycles after o_start, then a done tick.
    logic eng_busy = 1'b0;
    logic hold_busy = 1'b0;
    logic spur_en = 1'b0;
    int   eng_cnt = 0;
    int   eng_len = 5;
    assign i_busy = eng_busy | hold_busy;

    always @(negedge clk) begin
        if (rst) begin
            eng_busy    = 1'b0;
            eng_cnt     = 0;
            i_done_tick = 1'b0;
        end else begin
            i_done_tick = 1'b0;
            if (o_start) begin
                eng_busy = 1'b1;
                eng_cnt  = eng_len;
            end else if (eng_busy) begin
                if (eng_cnt == 0) begin
                    eng_busy    = 1'b0;
                    i_done_tick = 1'b1;
                end else begin
                    eng_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 15) == 0) begin
                i_done_tick = 1'b1;
            end
        end
    end

    // Reference model: byte list, pack queue, dispatch progress and pending ack.
    logic [7:0]        m_bytes[$];
    logic [PACK_W-1:0] m_q[$];
    int                m_idle;
    bit                m_pend, m_start_pend, m_wait, m_have, m_new_ack;
    logic [7:0]        m_code, m_sel;
    logic [PACK_W-1:0] m_pk;
    bit                e_start, e_txs, e_ferr;
    logic [7:0]        e_txd;
    logic [PACK_W-1:0] e_pk;
    int                e_level;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_bytes.delete(); m_q.delete();
            m_idle = 0; m_pend = 0; m_start_pend = 0; m_wait = 0; m_code = 8'h00;
            e_start = 0; e_txs = 0; e_ferr = 0; e_txd = 8'h00; e_pk = '0; e_level = 0;
        end else begin
            m_have = 0; m_new_ack = 0; e_start = 0; e_ferr = 0; e_txs = 0;
            // dispatch: pop uses the queue as it stood before this edge
            if (m_wait) begin
                if (i_done_tick) m_wait = 0;
            end else if (m_start_pend) begin
                if (!i_busy) begin e_start = 1; m_start_pend = 0; m_wait = 1; end
            end else if (m_q.size() > 0 && !i_busy) begin
                e_pk = m_q.pop_front();
                m_start_pend = 1;
            end
            // framing
            if (i_rx_done_tick) begin
                m_bytes.push_back(i_data);
                m_idle = 0;
                if (m_bytes.size() == PACK_NUM) begin
                    m_pk = '0;
                    foreach (m_bytes[k]) m_pk = (m_pk << 8) | PACK_W'(m_bytes[k]);
                    m_bytes.delete();
                    m_have = 1;
                end
            end else if (m_bytes.size() > 0) begin
                m_idle++;
                if (m_idle == TIMEOUT_CYC) begin
                    m_bytes.delete(); m_idle = 0; e_ferr = 1;
                end
            end
            // pack disposition
            if (m_have) begin
                m_new_ack = 1;
                if (m_pk[7:0] == 8'hFF) begin
                    m_q.delete(); m_sel = 8'h5A;
                end else if (m_q.size() < DEPTH) begin
                    m_q.push_back(m_pk); m_sel = 8'hA5;
                end else begin
                    m_sel = 8'hEE;
                end
            end
            // ack transmit
            if (m_pend && i_tx_ready) begin
                e_txs = 1; e_txd = m_code; m_pend = 0;
            end
            if (m_new_ack) begin
                m_pend = 1; m_code = m_sel;
            end
            e_level = m_q.size();
        end
    end

    // Per-cycle comparison and event logging.
    int                start_cnt = 0;
    int                ferr_cnt  = 0;
    logic [PACK_W-1:0] start_log[$];
    logic [7:0]        tx_log[$];

    always @(negedge clk) begin
        if (!rst) begin
            check("start", 80'(o_start), 80'(e_start));
            check("tx_start", 80'(o_tx_start), 80'(e_txs));
            check("tx_data", 80'(o_tx_data), 80'(e_txd));
            check("frame_err", 80'(o_frame_err), 80'(e_ferr));
            check("q_level", 80'(o_q_level), 80'(e_level));
            check("out_pack", 80'({o_pattern, o_freq, o_ctrl}), 80'(e_pk));
            if (o_start) begin start_cnt++; start_log.push_back({o_pattern, o_freq, o_ctrl}); end
            if (o_tx_start) tx_log.push_back(o_tx_data);
            if (o_frame_err) ferr_cnt++;
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        i_data = b; i_rx_done_tick = 1'b1;
        @(negedge clk);
        i_rx_done_tick = 1'b0; i_data = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_pack(input logic [31:0] pat, input logic [31:0] frq, input logic [7:0] ctl);
        logic [PACK_W-1:0] p;
        p = {pat, frq, ctl};
        for (int i = 0; i < PACK_NUM; i++) send_byte(p[PACK_W-1-8*i -: 8], 0);
    endtask

    task automatic wait_starts(input string tag, input int target, input int bound);
        int n;
        n = 0;
        while (start_cnt < target && n < bound) begin @(negedge clk); n++; end
        check(tag, 80'(start_cnt >= target), 80'(1));
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check({tag, "_start"}, 80'(o_start), 80'(0));
        check({tag, "_txs"}, 80'(o_tx_start), 80'(0));
        check({tag, "_ferr"}, 80'(o_frame_err), 80'(0));
        check({tag, "_lvl"}, 80'(o_q_level), 80'(0));
        check({tag, "_outs"}, 80'({o_pattern, o_freq, o_ctrl, o_tx_data}), 80'(0));
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, t0, f0, n;
        logic [31:0] rp, rf;
        logic [7:0]  rc;
        reset_pulse("reset");

        // basic pack
        send_pack(32'h12345678, 32'h0F0F00FF, 8'h01);
        wait_starts("t1_wait", 1, 50);
        check("t1_pack", 80'(start_log[start_log.size()-1]), 80'(72'h123456780F0F00FF01));
        settle(20);
        check("t1_ack", 80'(tx_log[tx_log.size()-1]), 80'(8'hA5));

        // queue full while engine held busy
        hold_busy = 1'b1; s0 = start_cnt; t0 = tx_log.size();
        send_pack(32'h11111111, 32'h22222222, 8'h11);
        send_pack(32'h33333333, 32'h44444444, 8'h22);
        send_pack(32'h55555555, 32'h66666666, 8'h33);
        settle(5);
        check("t2_level", 80'(o_q_level), 80'(2));
        check("t2_ntx", 80'(tx_log.size()), 80'(t0 + 3));
        if (tx_log.size() == t0 + 3)
            check("t2_acks", 80'({tx_log[t0], tx_log[t0+1], tx_log[t0+2]}), 80'(24'hA5A5EE));
        hold_busy = 1'b0;
        wait_starts("t2_wait", s0 + 2, 200);
        settle(40);
        check("t2_nstart", 80'(start_cnt), 80'(s0 + 2));
        if (start_cnt == s0 + 2)
            check("t2_order", 80'({start_log[s0][7:0], start_log[s0+1][7:0]}), 80'(16'h1122));

        // partial pack timeout
        f0 = ferr_cnt; t0 = tx_log.size();
        for (int i = 0; i < 4; i++) send_byte(8'hC0 + 8'(i), 0);
        settle(TIMEOUT_CYC + 5);
        check("t3_ferr", 80'(ferr_cnt), 80'(f0 + 1));
        check("t3_noack", 80'(tx_log.size()), 80'(t0));
        s0 = start_cnt;
        send_pack(32'hAABBCCDD, 32'h01020304, 8'h05);
        wait_starts("t3_wait", s0 + 1, 50);
        check("t3_pack", 80'(start_log[start_log.size()-1]), 80'(72'hAABBCCDD0102030405));
        settle(20);

        // flush with two queued
        hold_busy = 1'b1;
        send_pack(32'h41414141, 32'h41414141, 8'h41);
        send_pack(32'h42424242, 32'h42424242, 8'h42);
        send_pack(32'h00000000, 32'h00000000, 8'hFF);
        settle(5);
        check("t4_level", 80'(o_q_level), 80'(0));
        check("t4_ack", 80'(tx_log[tx_log.size()-1]), 80'(8'h5A));
        s0 = start_cnt; hold_busy = 1'b0;
        settle(60);
        check("t4_nostart", 80'(start_cnt), 80'(s0));

        // ack overwrite while tx not ready
        i_tx_ready = 1'b0; hold_busy = 1'b1; t0 = tx_log.size();
        send_pack(32'h51515151, 32'h51515151, 8'h51);
        send_pack(32'h52525252, 32'h52525252, 8'hFF);
        settle(10);
        check("t5_held", 80'(tx_log.size()), 80'(t0));
        i_tx_ready = 1'b1;
        settle(5);
        check("t5_one", 80'(tx_log.size()), 80'(t0 + 1));
        check("t5_code", 80'(tx_log[tx_log.size()-1]), 80'(8'h5A));
        hold_busy = 1'b0;
        settle(5);

        // reset mid-collect and mid-dispatch
        for (int i = 0; i < 4; i++) send_byte(8'h70 + 8'(i), 0);
        reset_pulse("t6a");
        eng_len = 50; s0 = start_cnt;
        send_pack(32'h61616161, 32'h62626262, 8'h63);
        wait_starts("t6_wait1", s0 + 1, 50);
        settle(5);
        reset_pulse("t6b");
        eng_len = 5; s0 = start_cnt;
        send_pack(32'hDEADBEEF, 32'hCAFEF00D, 8'h77);
        wait_starts("t6_wait2", s0 + 1, 50);
        check("t6_pack", 80'(start_log[start_log.size()-1]), 80'(72'hDEADBEEFCAFEF00D77));
        settle(20);

        // randomized traffic
        spur_en = 1'b1;
        repeat (150) begin
            hold_busy  = ($urandom_range(0, 5) == 0);
            i_tx_ready = ($urandom_range(0, 3) != 0);
            eng_len    = $urandom_range(0, 12);
            if ($urandom_range(0, 9) == 0) begin
                n = $urandom_range(1, PACK_NUM-1);
                for (int i = 0; i < n; i++)
                    send_byte(8'($urandom), (i == n-1) ? int'(TIMEOUT_CYC) - 1 - $urandom_range(0, 1) : 0);
            end else begin
                rp = $urandom; rf = $urandom;
                rc = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
                for (int i = 0; i < PACK_NUM; i++) begin
                    logic [PACK_W-1:0] p;
                    p = {rp, rf, rc};
                    send_byte(p[PACK_W-1-8*i -: 8],
                              ($urandom_range(0, 19) == 0) ? int'(TIMEOUT_CYC) - 2 : $urandom_range(0, 2));
                end
            end
            settle($urandom_range(0, 20));
        end
        hold_busy = 1'b0; i_tx_ready = 1'b1; spur_en = 1'b0;
        settle(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
